sha_core_arbiter: RTL and testbench
===================================

SHA_CORE_ARBITER -- requirements
Module: sha_core_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one sha256 compression core (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles waited for core_done before aborting.
REQ-003 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester request, level.
REQ-006 SHALL have port req_block  input  NUM_REQ*512  per-requester 16-word message block, requester i at bits [512*i +: 512].
REQ-007 SHALL have port req_hash  input  NUM_REQ*256  per-requester chaining value h0..h7, h0 in MSBs.
REQ-008 SHALL have port gnt  output  NUM_REQ  one-hot grant pulse.
REQ-009 SHALL have port rsp_valid  output  NUM_REQ  one-hot response pulse.
REQ-010 SHALL have port rsp_hash  output  256  result hash, shared by all requesters.
REQ-011 SHALL have port rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-012 SHALL have port core_start  output  1  one-cycle start to the core.
REQ-013 SHALL have port core_block  output  512  block to the core, held stable from core_start until core_done.
REQ-014 SHALL have port core_hash_in  output  256  chaining value to the core, held stable like core_block.
REQ-015 SHALL have port core_done  input  1  core completion pulse.
REQ-016 SHALL have port core_hash_out  input  256  core result, valid when core_done=1.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, LAUNCH, WAIT, RESP.
REQ-019 In IDLE with any req bit set, SHALL select the winner by round-robin, starting the search at pointer ptr and wrapping past NUM_REQ-1 to 0.
REQ-020 On selection, SHALL latch the winner's req_block and req_hash into core_block and core_hash_in, pulse gnt[winner] for exactly one cycle on the next edge, and enter LAUNCH.
REQ-021 In LAUNCH, SHALL drive core_start=1 for exactly one cycle, clear the watchdog counter, and enter WAIT.
REQ-022 In WAIT, SHALL increment the watchdog counter each cycle; on core_done=1, SHALL capture core_hash_out into rsp_hash with rsp_err=0 and enter RESP.
REQ-023 When the WAIT watchdog count reaches TIMEOUT without core_done, SHALL set rsp_hash=0 and rsp_err=1, and enter RESP.
REQ-024 In RESP, SHALL pulse rsp_valid[winner] for one cycle, set ptr=(winner+1) mod NUM_REQ, and return to IDLE.
REQ-025 Latency: req seen in IDLE -> gnt +1 cycle; core_start +2; rsp_valid +1 cycle after core_done.
REQ-026 rsp_hash and rsp_err SHALL hold their values until the next RESP.
REQ-027 core_done SHALL be ignored outside WAIT, including a late core_done arriving after a timeout.
REQ-028 Changes to req or req_block after grant SHALL have no effect on the transaction in flight.
REQ-029 A requester holding req high through RESP SHALL compete again; with all req high, grants SHALL rotate 0,1,...,NUM_REQ-1,0.
REQ-030 Back-to-back: from RESP, IDLE SHALL grant a pending request on the following cycle (5 cycles minimum per transaction plus core time).

Reset
REQ-031 On reset_n=0, SHALL set state=IDLE, ptr=0, watchdog counter=0, and drive gnt, rsp_valid, core_start, rsp_err, busy and rsp_hash to 0; core_block and core_hash_in SHALL be 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no rsp_valid; a core_done arriving later SHALL be ignored per REQ-027.

Structure
REQ-033 Shared package sha_pkg SHALL hold the state enum, the block_t (512-bit) and hash_t (256-bit) typedefs, and the SHA-256 initial hash constants.
REQ-034 The round-robin picker SHALL be a combinational sub-module rr_arbiter (inputs req, ptr; outputs winner index, any).

Verification
REQ-035 Single req[2]=1, core_done 70 cycles after core_start -> gnt=4'b0100 at +1, core_start at +2, rsp_valid=4'b0100 one cycle after core_done, rsp_hash equals core_hash_out.
REQ-036 req=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-037 req[1] with core_done never asserted, TIMEOUT=255 -> rsp_valid[1] with rsp_err=1 and rsp_hash=0, 255 cycles after entering WAIT; a later core_done is ignored.
REQ-038 req_block changed one cycle after gnt -> core_block retains the original value until core_done.
REQ-039 reset_n pulsed low during WAIT -> all outputs 0, ptr=0; a subsequent core_done produces no rsp_valid.
REQ-040 Golden check: "abc" padded block with standard initial hash -> rsp_hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-256 core arbiter slice.
package sha_pkg;

  localparam int BLOCK_W = 512;
  localparam int HASH_W  = 256;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [HASH_W-1:0]  hash_t;

  // Arbiter transaction states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // SHA-256 initial hash values h0..h7, h0 in the MSBs.
  localparam hash_t SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               any
);

  localparam logic [PTR_W:0] NUM_EXT = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0] w_idx;

  // Scan from the farthest candidate to the nearest so the nearest set
  // request (closest to ptr) is the one left in winner.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    w_idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (w_idx >= NUM_EXT) w_idx = w_idx - NUM_EXT;
      if (req[w_idx[PTR_W-1:0]]) begin
        winner = w_idx[PTR_W-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha_core_arbiter.sv
// Shares one SHA-256 compression core between NUM_REQ requesters.
//
// Handshakes: req is a level held by a requester; gnt[i] pulses one cycle
// when requester i is accepted (its req_block/req_hash are captured then, so
// later changes are ignored). core_start pulses one cycle with core_block and
// core_hash_in stable until core_done; core_done is honoured only in WAIT.
// rsp_valid[i] pulses one cycle; rsp_hash/rsp_err hold until the next response.
module sha_core_arbiter
  import sha_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*512-1:0]   req_block,
  input  logic [NUM_REQ*256-1:0]   req_hash,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [255:0]             rsp_hash,
  output logic                     rsp_err,
  output logic                     core_start,
  output logic [511:0]             core_block,
  output logic [255:0]             core_hash_in,
  input  logic                     core_done,
  input  logic [255:0]             core_hash_out,
  output logic                     busy,
  output state_t                   o_dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_winner;
  logic [PTR_W-1:0]   w_winner;
  logic               w_any;
  logic [CNT_W-1:0]   r_wdog;
  logic               w_wdog_last;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_rsp_valid;
  hash_t              r_rsp_hash;
  logic               r_rsp_err;
  logic               r_core_start;
  block_t             r_core_block;
  hash_t              r_core_hash_in;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

  // Last WAIT cycle before the watchdog gives up on the core.
  assign w_wdog_last = (r_wdog == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = LAUNCH;
      LAUNCH:  w_state_nxt = WAIT;
      WAIT:    if (core_done || w_wdog_last) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on grant, pulse generation, watchdog, response and pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr          <= '0;
      r_winner       <= '0;
      r_wdog         <= '0;
      r_gnt          <= '0;
      r_rsp_valid    <= '0;
      r_rsp_hash     <= '0;
      r_rsp_err      <= 1'b0;
      r_core_start   <= 1'b0;
      r_core_block   <= '0;
      r_core_hash_in <= '0;
    end else begin
      r_gnt        <= '0;
      r_rsp_valid  <= '0;
      r_core_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_winner       <= w_winner;
            r_gnt          <= ONE_HOT0 << w_winner;
            r_core_block   <= req_block[BLOCK_W*w_winner +: BLOCK_W];
            r_core_hash_in <= req_hash[HASH_W*w_winner +: HASH_W];
          end
        end
        LAUNCH: begin
          r_core_start <= 1'b1;
          r_wdog       <= '0;
        end
        WAIT: begin
          r_wdog <= r_wdog + 1'b1;
          if (core_done) begin
            r_rsp_hash  <= core_hash_out;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= ONE_HOT0 << r_winner;
          end else if (w_wdog_last) begin
            r_rsp_hash  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= ONE_HOT0 << r_winner;
          end
        end
        RESP: begin
          r_ptr <= (r_winner == PTR_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt          = r_gnt;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_hash     = r_rsp_hash;
  assign rsp_err      = r_rsp_err;
  assign core_start   = r_core_start;
  assign core_block   = r_core_block;
  assign core_hash_in = r_core_hash_in;
  assign busy         = (r_state != IDLE);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_sha_core_arbiter.sv
// Bench for sha_core_arbiter: a behavioural SHA-256 core, directed
// transactions and a grant/response scoreboard checked by a monitor.
module tb_sha_core_arbiter;
  import sha_pkg::*;

  localparam int N  = 4;
  localparam int TO = 255;
  localparam int GW = N + 512 + 256;
  localparam int RW = N + 1 + 256;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req;
  logic [N*512-1:0] req_block;
  logic [N*256-1:0] req_hash;
  logic [N-1:0]     gnt, rsp_valid;
  logic [255:0]     rsp_hash, core_hash_in, core_hash_out;
  logic [511:0]     core_block;
  logic             rsp_err, core_start, core_done, busy;
  state_t           dbg_state;

  always #5 clk = ~clk;

  sha_core_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_block(req_block),
    .req_hash(req_hash), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_hash(rsp_hash),
    .rsp_err(rsp_err), .core_start(core_start), .core_block(core_block),
    .core_hash_in(core_hash_in), .core_done(core_done),
    .core_hash_out(core_hash_out), .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- counters and checking helpers ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- SHA-256 reference ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [511:0] mk_blk(input logic [31:0] s);
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[511-32*k -: 32] = s * 32'h01000193 + 32'(k);
    return b;
  endfunction

  function automatic logic [255:0] mk_hash(input logic [31:0] s);
    logic [255:0] hv;
    for (int k = 0; k < 8; k++) hv[255-32*k -: 32] = s ^ (32'h9e3779b9 * 32'(k + 1));
    return hv;
  endfunction

  // ---------------- behavioural core ----------------
  int       core_lat   = 3;   // cycles from core_start to core_done; <=0 never answers
  bit       stray_done = 1'b0;
  bit       core_pend;
  int       core_cnt;
  logic [255:0] core_res;

  initial begin
    core_done = 1'b0; core_hash_out = '0; core_pend = 1'b0; core_cnt = 0; core_res = '0;
    forever begin
      @(posedge clk); #2;
      core_done = 1'b0;
      if (!reset_n) core_pend = 1'b0;
      else if (core_start) begin
        core_res  = sha_compress(core_hash_in, core_block);
        core_pend = (core_lat > 0);
        core_cnt  = core_lat;
      end else if (core_pend) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done = 1'b1; core_hash_out = core_res; core_pend = 1'b0;
        end
      end
      if (stray_done) begin
        core_done = 1'b1; core_hash_out = {8{32'hdeadbeef}}; stray_done = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [GW-1:0] gnt_q[$];   // {gnt, block, hash} expected at each grant
  logic [RW-1:0] exp_q[$];   // {rsp_valid, rsp_err, rsp_hash} expected at each response

  task automatic set_req(input int i, input logic [511:0] blk, input logic [255:0] hv);
    req_block[512*i +: 512] = blk;
    req_hash[256*i +: 256]  = hv;
  endtask

  task automatic push_gnt(input int i);
    gnt_q.push_back({N'(1 << i), req_block[512*i +: 512], req_hash[256*i +: 256]});
  endtask

  task automatic expect_txn(input int i, input logic err, input logic [255:0] rh);
    push_gnt(i);
    exp_q.push_back({N'(1 << i), err, rh});
  endtask

  function automatic logic [255:0] exp_of(input int i);
    return sha_compress(req_hash[256*i +: 256], req_block[512*i +: 512]);
  endfunction

  // ---------------- monitor ----------------
  int cyc = 0, t_gnt = -100, t_start = -100, t_done = -100, t_rsp = -100;
  bit b2b_mode = 1'b0, b2b_seen = 1'b0;
  logic [511:0] cur_blk = '0;
  logic [255:0] cur_hash = '0;

  initial begin
    logic [GW-1:0] ge;
    logic [RW-1:0] re;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (|gnt) begin
          if (gnt_q.size() == 0) check("unexpected_gnt", gnt, '0);
          else begin
            ge = gnt_q.pop_front();
            check("gnt", gnt, ge[GW-1 -: N]);
            cur_blk  = ge[767:256];
            cur_hash = ge[255:0];
            if (b2b_mode && b2b_seen) check("b2b_gap", cyc - t_rsp, 2);
            b2b_seen = b2b_mode;
          end
          t_gnt = cyc;
        end
        if (core_start) begin
          check("start_lat", cyc - t_gnt, 1);
          check("core_block", core_block, cur_blk);
          check("core_hash_in", core_hash_in, cur_hash);
          t_start = cyc;
        end
        if (core_done && dbg_state == WAIT) begin
          t_done = cyc;
          check("block_hold", core_block, cur_blk);
        end
        if (|rsp_valid) begin
          if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid, '0);
          else begin
            re = exp_q.pop_front();
            check("rsp_valid", rsp_valid, re[RW-1 -: N]);
            check("rsp_err", rsp_err, re[256]);
            check("rsp_hash", rsp_hash, re[255:0]);
            if (re[256]) check("timeout_lat", cyc - t_start, TO);
            else         check("rsp_lat", cyc - t_done, 1);
          end
          t_rsp = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(output int lat);
    lat = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (|gnt) begin lat = k; return; end
    end
    fail_now("gnt_wait");
  endtask

  task automatic drain(input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (gnt_q.size() == 0 && exp_q.size() == 0 && !busy) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    fail_now("drain");
    gnt_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [255:0] eh;
    logic [511:0] abc_blk;
    req = '0; req_block = '0; req_hash = '0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_gnt", gnt, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_core_start", core_start, '0);
    check("rst_rsp_err", rsp_err, '0);
    check("rst_busy", busy, '0);
    check("rst_rsp_hash", rsp_hash, '0);
    check("rst_core_block", core_block, '0);
    check("rst_core_hash_in", core_hash_in, '0);
    check("rst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    @(negedge clk);

    // All requesters held high: grants rotate 0,1,2,3,0,1,2,3 back to back.
    for (int i = 0; i < N; i++) set_req(i, mk_blk(32'h100 + 32'(i)), mk_hash(32'h200 + 32'(i)));
    core_lat = 3;
    b2b_mode = 1'b1; b2b_seen = 1'b0;
    for (int k = 0; k < 8; k++) expect_txn(k % N, 1'b0, exp_of(k % N));
    req = '1;
    for (int k = 0; k < 8; k++) wait_gnt(lat);
    req = '0;
    drain(200);
    b2b_mode = 1'b0;

    // Single requester 2, core answers 70 cycles after start.
    set_req(2, mk_blk(32'h0bad_cafe), mk_hash(32'h1234_5678));
    eh = exp_of(2);
    core_lat = 70;
    expect_txn(2, 1'b0, eh);
    req = 4'b0100;
    wait_gnt(lat);
    req = '0;
    check("gnt_lat", lat, 1);
    drain(300);
    repeat (3) @(negedge clk);
    check("hash_hold", rsp_hash, eh);
    check("err_hold", rsp_err, 1'b0);

    // Requester 1 with a silent core: watchdog timeout, later core_done ignored.
    set_req(1, mk_blk(32'h77), mk_hash(32'h88));
    core_lat = 0;
    expect_txn(1, 1'b1, '0);
    req = 4'b0010;
    wait_gnt(lat);
    req = '0;
    drain(600);
    check("to_err_hold", rsp_err, 1'b1);
    check("to_hash_zero", rsp_hash, '0);
    stray_done = 1'b1;
    repeat (5) @(negedge clk);
    check("late_done_err", rsp_err, 1'b1);
    check("late_done_hash", rsp_hash, '0);
    check("late_done_busy", busy, 1'b0);

    // Requester 0 changes its block and hash right after the grant.
    set_req(0, mk_blk(32'haaaa), mk_hash(32'hbbbb));
    core_lat = 20;
    expect_txn(0, 1'b0, exp_of(0));
    req = 4'b0001;
    wait_gnt(lat);
    @(negedge clk);
    set_req(0, mk_blk(32'h5555), mk_hash(32'h6666));
    req = '0;
    drain(200);

    // Golden vector: "abc" padded block with the standard initial hash.
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    set_req(1, abc_blk, {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19});
    core_lat = 10;
    expect_txn(1, 1'b0, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    req = 4'b0010;
    wait_gnt(lat);
    req = '0;
    drain(200);

    // Reset during WAIT: transaction abandoned, pointer back to 0.
    set_req(2, mk_blk(32'h4242), mk_hash(32'h4343));
    core_lat = 0;
    push_gnt(2);
    req = 4'b0100;
    wait_gnt(lat);
    req = '0;
    repeat (10) @(negedge clk);
    check("pre_rst_state", dbg_state, WAIT);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_gnt", gnt, '0);
    check("mid_rst_rsp_valid", rsp_valid, '0);
    check("mid_rst_core_start", core_start, '0);
    check("mid_rst_rsp_err", rsp_err, '0);
    check("mid_rst_busy", busy, '0);
    check("mid_rst_rsp_hash", rsp_hash, '0);
    check("mid_rst_core_block", core_block, '0);
    check("mid_rst_core_hash_in", core_hash_in, '0);
    check("mid_rst_state", dbg_state, IDLE);
    @(posedge clk); #3 reset_n = 1'b1;
    stray_done = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    for (int i = 0; i < N; i++) set_req(i, mk_blk(32'h300 + 32'(i)), mk_hash(32'h400 + 32'(i)));
    core_lat = 4;
    expect_txn(0, 1'b0, exp_of(0));
    req = '1;
    wait_gnt(lat);
    req = '0;
    drain(200);

    check("scoreboard_left", 32'(gnt_q.size() + exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
